// File: rtl/serial_uart.sv
// serial_uart: 8N1 UART with first-word-fall-through RX FIFO and a TX FIFO.
// Bit timing is a whole number of clocks per bit, set by CLKS_PER_BIT.

// Synchronous FIFO with registered head/empty/full flags.
module serial_uart_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr_n;
   logic [PTR_W-1:0] rd_ptr_n;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_n;
   logic [WIDTH-1:0] head_n;
   logic             push_ok;
   logic             pop_ok;

   // Accept/pop decisions and the head value that will be visible after this edge.
   always_comb begin
      pop_ok   = pop && (count != '0);
      push_ok  = push && ((count != DEPTH_C) || pop_ok);
      rd_ptr_n = rd_ptr + PTR_W'(pop_ok);
      wr_ptr_n = wr_ptr + PTR_W'(push_ok);
      count_n  = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      head_n   = head;
      if (count_n != '0) begin
         // The incoming byte becomes the head when nothing older survives this edge.
         if ((count - CNT_W'(pop_ok)) == '0) begin
            head_n = din;
         end else begin
            head_n = mem[rd_ptr_n];
         end
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and registered status flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         count  <= count_n;
         head   <= head_n;
         empty  <= (count_n == '0);
         full   <= (count_n == DEPTH_C);
      end
   end

endmodule

module serial_uart #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] rd_data,
   output logic       rx_empty,
   input  logic       rd_en,
   input  logic [7:0] wr_data,
   input  logic       wr_en,
   output logic       tx_full,
   output logic       rx_overrun,
   output logic       framing_err
);

   localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF_BITS = CLKS_PER_BIT / 2;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF_BITS > 0) ? HALF_BITS - 1 : 0);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   // ---------------- receive path ----------------
   logic             rx_meta;
   logic             rx_sync;
   uart_state_t      rx_state;
   uart_state_t      rx_state_n;
   logic [CNT_W-1:0] rx_cnt;
   logic [CNT_W-1:0] rx_cnt_n;
   logic [2:0]       rx_bit;
   logic [2:0]       rx_bit_n;
   logic [7:0]       rx_shift;
   logic [7:0]       rx_shift_n;
   logic             rx_wait;
   logic             rx_wait_n;
   logic             rx_push_c;
   logic             ferr_c;
   logic             rx_fifo_full;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // RX next-state: mid-bit sampling, byte assembly, stop-bit validation.
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt + CNT_W'(1);
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_wait_n  = rx_wait;
      rx_push_c  = 1'b0;
      ferr_c     = 1'b0;
      case (rx_state)
         IDLE: begin
            rx_cnt_n = '0;
            if (rx_wait) begin
               // After a bad stop bit the line must return high before a new start.
               if (rx_sync) begin
                  rx_wait_n = 1'b0;
               end
            end else if (!rx_sync) begin
               rx_state_n = START;
            end
         end
         START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_n = '0;
               rx_bit_n = '0;
               rx_state_n = rx_sync ? IDLE : DATA;
            end
         end
         DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_sync, rx_shift[7:1]};
               if (rx_bit == 3'd7) begin
                  rx_state_n = STOP;
               end else begin
                  rx_bit_n = rx_bit + 3'd1;
               end
            end
         end
         STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_n   = '0;
               rx_state_n = IDLE;
               if (rx_sync) begin
                  rx_push_c = 1'b1;
               end else begin
                  ferr_c    = 1'b1;
                  rx_wait_n = 1'b1;
               end
            end
         end
         default: rx_state_n = IDLE;
      endcase
   end

   // RX state register plus the registered error flags.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_state    <= IDLE;
         rx_cnt      <= '0;
         rx_bit      <= '0;
         rx_shift    <= '0;
         rx_wait     <= 1'b0;
         framing_err <= 1'b0;
         rx_overrun  <= 1'b0;
      end else begin
         rx_state    <= rx_state_n;
         rx_cnt      <= rx_cnt_n;
         rx_bit      <= rx_bit_n;
         rx_shift    <= rx_shift_n;
         rx_wait     <= rx_wait_n;
         framing_err <= ferr_c;
         // A full FIFO with no simultaneous pop drops the byte.
         rx_overrun  <= rx_overrun | (rx_push_c & rx_fifo_full & ~rd_en);
      end
   end

   serial_uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_rx_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (rx_push_c),
      .din     (rx_shift),
      .pop     (rd_en),
      .head    (rd_data),
      .empty   (rx_empty),
      .full    (rx_fifo_full)
   );

   // ---------------- transmit path ----------------
   uart_state_t      tx_state;
   uart_state_t      tx_state_n;
   logic [CNT_W-1:0] tx_cnt;
   logic [CNT_W-1:0] tx_cnt_n;
   logic [2:0]       tx_bit;
   logic [2:0]       tx_bit_n;
   logic [7:0]       tx_byte;
   logic [7:0]       tx_byte_n;
   logic             tx_pop_c;
   logic             tx_line_c;
   logic [7:0]       tx_head;
   logic             tx_empty;

   serial_uart_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (wr_en),
      .din     (wr_data),
      .pop     (tx_pop_c),
      .head    (tx_head),
      .empty   (tx_empty),
      .full    (tx_full)
   );

   // TX next-state: pops a byte and shifts out start, data LSB first, stop.
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt + CNT_W'(1);
      tx_bit_n   = tx_bit;
      tx_byte_n  = tx_byte;
      tx_pop_c   = 1'b0;
      tx_line_c  = 1'b1;
      case (tx_state)
         IDLE: begin
            tx_cnt_n = '0;
            if (!tx_empty) begin
               tx_pop_c   = 1'b1;
               tx_byte_n  = tx_head;
               tx_state_n = START;
            end
         end
         START: begin
            tx_line_c = 1'b0;
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n   = '0;
               tx_bit_n   = '0;
               tx_state_n = DATA;
            end
         end
         DATA: begin
            tx_line_c = tx_byte[tx_bit];
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n = '0;
               if (tx_bit == 3'd7) begin
                  tx_state_n = STOP;
               end else begin
                  tx_bit_n = tx_bit + 3'd1;
               end
            end
         end
         STOP: begin
            tx_line_c = 1'b1;
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n = '0;
               // Chain straight into the next frame when more bytes are queued.
               if (!tx_empty) begin
                  tx_pop_c   = 1'b1;
                  tx_byte_n  = tx_head;
                  tx_state_n = START;
               end else begin
                  tx_state_n = IDLE;
               end
            end
         end
         default: tx_state_n = IDLE;
      endcase
   end

   // TX state register; the line is registered one cycle behind the state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_byte  <= '0;
         tx       <= 1'b1;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_byte  <= tx_byte_n;
         tx       <= tx_line_c;
      end
   end

endmodule

// File: tb/tb_serial_uart.sv
// tb_serial_uart: directed stimulus with a frame-level reference model of serial_uart.
module tb_serial_uart;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int FRAME = 10 * CPB;
   // Edges from the first line-low sample to the stop-bit sample: 2 sync + half bit + 9 bits.
   localparam int RX_LAT = 2 + CPB / 2 + 9 * CPB;

   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic       rx;
   logic       tx;
   logic [7:0] rd_data;
   logic       rx_empty;
   logic       rd_en;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       tx_full;
   logic       rx_overrun;
   logic       framing_err;

   int checks = 0;
   int errors = 0;

   serial_uart #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .rx          (rx),
      .tx          (tx),
      .rd_data     (rd_data),
      .rx_empty    (rx_empty),
      .rd_en       (rd_en),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .tx_full     (tx_full),
      .rx_overrun  (rx_overrun),
      .framing_err (framing_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         n = 0;
   int         tx_free = 0;
   int         tx_start = 0;
   logic       tx_busy = 1'b0;
   logic [9:0] tx_frame = '1;
   logic [7:0] tq[$];
   logic [7:0] rq[$];
   int         ev_due[$];
   logic [7:0] ev_byte[$];
   logic       ev_good[$];
   logic       exp_tx = 1'b1;
   logic       exp_full = 1'b0;
   logic       exp_empty = 1'b1;
   logic       exp_ovr = 1'b0;
   logic       exp_ferr = 1'b0;
   logic [7:0] exp_rd = 8'h00;
   logic       m_tpop;
   logic       m_tacc;
   logic       m_rpop;
   logic       m_good;
   logic [7:0] m_byte;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tq.delete();
         rq.delete();
         ev_due.delete();
         ev_byte.delete();
         ev_good.delete();
         tx_busy   = 1'b0;
         tx_free   = 0;
         exp_tx    = 1'b1;
         exp_full  = 1'b0;
         exp_empty = 1'b1;
         exp_ovr   = 1'b0;
         exp_ferr  = 1'b0;
         exp_rd    = 8'h00;
      end else begin
         n++;
         // Transmitter: one frame every FRAME edges while bytes are queued.
         m_tpop = (tq.size() > 0) && (n >= tx_free);
         m_tacc = wr_en && ((tq.size() < DEPTH) || m_tpop);
         if (m_tpop) begin
            m_byte   = tq.pop_front();
            tx_frame = {1'b1, m_byte, 1'b0};
            tx_start = n;
            tx_free  = n + FRAME;
            tx_busy  = 1'b1;
         end
         if (m_tacc) tq.push_back(wr_data);
         exp_tx = 1'b1;
         if (tx_busy && (n > tx_start) && (n <= tx_start + FRAME))
            exp_tx = tx_frame[(n - tx_start - 1) / CPB];
         exp_full = (tq.size() == DEPTH);
         // Receiver: bytes land at their stop-bit sample edge.
         m_rpop   = rd_en && (rq.size() > 0);
         exp_ferr = 1'b0;
         if (m_rpop) void'(rq.pop_front());
         if ((ev_due.size() > 0) && (ev_due[0] == n)) begin
            void'(ev_due.pop_front());
            m_good = ev_good.pop_front();
            m_byte = ev_byte.pop_front();
            if (!m_good) exp_ferr = 1'b1;
            else if (rq.size() < DEPTH) rq.push_back(m_byte);
            else exp_ovr = 1'b1;
         end
         exp_empty = (rq.size() == 0);
         if (rq.size() > 0) exp_rd = rq[0];
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(posedge clock) begin
      #1;
      if (reset_n) begin
         check("cmp_tx", tx, exp_tx);
         check("cmp_tx_full", tx_full, exp_full);
         check("cmp_rx_empty", rx_empty, exp_empty);
         check("cmp_rd_data", rd_data, exp_rd);
         check("cmp_rx_overrun", rx_overrun, exp_ovr);
         check("cmp_framing_err", framing_err, exp_ferr);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < CPB; j++) begin
            @(negedge clock);
            if ((i == 0) && (j == 0)) begin
               ev_due.push_back(n + 1 + RX_LAT);
               ev_byte.push_back(b);
               ev_good.push_back(stop);
            end
            rx = f[i];
         end
      end
   endtask

   task automatic pop_rx();
      @(negedge clock);
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
   endtask

   task automatic wait_rx_ready(input int budget);
      int k;
      k = 0;
      while (rx_empty && (k < budget)) begin
         @(posedge clock);
         #1;
         k++;
      end
      check("rx_ready_timeout", rx_empty, 1'b0);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_tx"}, tx, 1'b1);
      check({tag, "_rx_empty"}, rx_empty, 1'b1);
      check({tag, "_tx_full"}, tx_full, 1'b0);
      check({tag, "_rd_data"}, rd_data, 8'h00);
      check({tag, "_rx_overrun"}, rx_overrun, 1'b0);
      check({tag, "_framing_err"}, framing_err, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] a5_seq;
      int         hi;
      int         zc;
      int         zc_exp;
      logic [7:0] b;
      a5_seq  = 10'b1101001010;
      rx      = 1'b1;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;

      // Reset values.
      #2 reset_n = 1'b0;
      #1 reset_checks("rst0");
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);

      // Single TX of 0xA5: idle for two edges, then the 10-bit frame.
      @(negedge clock);
      wr_en   = 1'b1;
      wr_data = 8'hA5;
      @(posedge clock);
      #1 check("tx_a5_after_E", tx, 1'b1);
      @(negedge clock);
      wr_en = 1'b0;
      @(posedge clock);
      #1 check("tx_a5_after_E1", tx, 1'b1);
      for (int k = 0; k < FRAME; k++) begin
         @(posedge clock);
         #1 check("tx_a5_bit", tx, a5_seq[k / CPB]);
      end
      repeat (5) @(negedge clock);

      // Single RX of 0x3C, then pops including one on an empty FIFO.
      send_frame(8'h3C, 1'b1);
      wait_rx_ready(20);
      check("rx_3c_data", rd_data, 8'h3C);
      pop_rx();
      check("rx_3c_empty_after_pop", rx_empty, 1'b1);
      pop_rx();
      check("rx_pop_empty_data_hold", rd_data, 8'h3C);
      check("rx_pop_empty_still_empty", rx_empty, 1'b1);

      // Framing error on 0x55, then a clean 0x66.
      send_frame(8'h55, 1'b0);
      @(negedge clock);
      rx = 1'b1;
      hi = 0;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (framing_err) hi++;
      end
      check("ferr_pulse_cycles", hi, 1);
      check("ferr_no_byte", rx_empty, 1'b1);
      repeat (2 * CPB) @(negedge clock);
      send_frame(8'h66, 1'b1);
      wait_rx_ready(20);
      check("rx_66_data", rd_data, 8'h66);
      pop_rx();

      // Overrun: nine frames into an eight-entry FIFO.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
      repeat (8) @(negedge clock);
      check("ovr_set", rx_overrun, 1'b1);
      for (int i = 0; i < 8; i++) begin
         check("ovr_pop_data", rd_data, 8'(i + 1));
         pop_rx();
      end
      check("ovr_drained_empty", rx_empty, 1'b1);
      check("ovr_sticky", rx_overrun, 1'b1);

      // TX full: ten back-to-back writes, the tenth is dropped.
      zc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         wr_en   = 1'b1;
         wr_data = 8'(8'h10 + i);
         @(posedge clock);
         #1 check("tx_full_edge", tx_full, (i >= 8));
         if (!tx) zc++;
      end
      @(negedge clock);
      wr_en = 1'b0;
      repeat (9 * FRAME + 10) begin
         @(posedge clock);
         #1;
         if (!tx) zc++;
      end
      zc_exp = 0;
      for (int i = 0; i < 9; i++) begin
         b = 8'(8'h10 + i);
         zc_exp += (1 + 8 - $countones(b)) * CPB;
      end
      check("tx_full_zero_cells", zc, zc_exp);
      check("tx_full_cleared", tx_full, 1'b0);

      // Reset during data bit 3 of 0xFF with three more bytes queued.
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         wr_en   = 1'b1;
         wr_data = (i == 0) ? 8'hFF : 8'(8'h40 + i);
      end
      @(negedge clock);
      wr_en = 1'b0;
      repeat (16) @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("rst_mid_tx", tx, 1'b1);
      check("rst_mid_tx_full", tx_full, 1'b0);
      check("rst_mid_overrun_clear", rx_overrun, 1'b0);
      check("rst_mid_rx_empty", rx_empty, 1'b1);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      zc = 0;
      repeat (100) begin
         @(posedge clock);
         #1;
         if (!tx) zc++;
      end
      check("rst_no_tx_after_release", zc, 0);

      // Push and pop on the same edge with a full RX FIFO: no overrun.
      for (int i = 0; i < 8; i++) send_frame(8'(8'h21 + i), 1'b1);
      send_frame(8'h29, 1'b1);
      pop_rx();
      repeat (5) @(negedge clock);
      check("full_pushpop_no_ovr", rx_overrun, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check("full_pushpop_data", rd_data, 8'(8'h22 + i));
         pop_rx();
      end
      check("full_pushpop_empty", rx_empty, 1'b1);

      repeat (5) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_uart.md
SERIAL_UART -- requirements
Module: serial_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per FIFO; power of two, at least 2.
REQ-003 SHALL have port clock, input, 1, the single system clock; all flops rise-edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, serial receive line, idle high, asynchronous to clock.
REQ-006 SHALL have port tx, output, 1, serial transmit line, idle high.
REQ-007 SHALL have port rd_data, output, 8, head of the RX FIFO; feeds the IO controller SerialData_in.
REQ-008 SHALL have port rx_empty, output, 1, high when the RX FIFO is empty; feeds SerialEmpty.
REQ-009 SHALL have port rd_en, input, 1, pops the RX FIFO head; driven by SerialRead.
REQ-010 SHALL have port wr_data, input, 8, byte to transmit; driven by SerialData_out.
REQ-011 SHALL have port wr_en, input, 1, pushes wr_data into the TX FIFO; driven by SerialWrite.
REQ-012 SHALL have port tx_full, output, 1, high when the TX FIFO is full; feeds SerialFull.
REQ-013 SHALL have port rx_overrun, output, 1, sticky flag for a received byte dropped because the RX FIFO was full.
REQ-014 SHALL have port framing_err, output, 1, one-cycle pulse for a bad stop bit.

Function
REQ-015 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts CLKS_PER_BIT cycles.
REQ-016 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-017 RX FSM states SHALL be IDLE, START, DATA, STOP.
  - IDLE->START on synchronized rx low.
  - START: sample at CLKS_PER_BIT/2; rx high -> IDLE (glitch rejected), else -> DATA.
  - DATA: sample each bit at CLKS_PER_BIT intervals from the mid-start point; -> STOP after bit 7.
REQ-018 RX STOP bit sampled 1 SHALL push the byte into the RX FIFO and return the FSM to IDLE.
REQ-019 RX STOP bit sampled 0 SHALL discard the byte, pulse framing_err for one cycle, and hold the FSM in IDLE until rx is sampled high.
REQ-020 A push into a full RX FIFO SHALL drop the byte and set rx_overrun, which stays high until reset; push with simultaneous rd_en on a full FIFO SHALL accept both, no overrun.
REQ-021 RX FIFO SHALL be first-word-fall-through: rd_data valid whenever rx_empty=0; rd_en pops on the edge it is sampled high; rd_en while empty ignored, rd_data unchanged.
REQ-022 wr_en with tx_full=0 SHALL push wr_data; wr_en with tx_full=1 SHALL be ignored and the byte dropped; simultaneous push and TX pop on a full FIFO SHALL accept both.
REQ-023 TX FSM states SHALL be IDLE, START, DATA, STOP.
  - IDLE: pops the TX FIFO on the first edge it is non-empty.
  - Drives start, 8 data bits, stop, each CLKS_PER_BIT cycles.
  - After STOP: -> START directly if the FIFO is non-empty (no idle gap), else -> IDLE.
REQ-024 tx SHALL be a registered output. wr_en sampled at edge E into an empty FIFO with TX idle -> pop at E+1 -> tx low after E+2.
REQ-025 FIFO occupancy counters SHALL be log2(FIFO_DEPTH)+1 bits; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 tx_full and rx_empty SHALL be registered and update on the same edge as the occupancy change.

Reset
REQ-027 reset_n low SHALL immediately force:
  - tx=1, rx_empty=1, tx_full=0, rd_data=0x00, rx_overrun=0, framing_err=0;
  - both FIFOs empty and both FSMs in IDLE.
REQ-028 Reset mid-frame SHALL abort the frame; no partial byte SHALL be stored or transmitted after release.
REQ-029 After reset_n rises, the first rx sample SHALL occur on the next edge; a line already low SHALL be treated as a start bit.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-030 Single TX: wr_en one cycle with 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, 4 cycles each; tx low after E+2.
REQ-031 Single RX: drive frame 0x3C on rx -> rx_empty falls after stop sample, rd_data=0x3C; rd_en one cycle -> rx_empty=1.
REQ-032 RX overrun: 9 frames 0x01..0x09, no rd_en -> rx_overrun=1; 8 pops return 0x01..0x08, then rx_empty=1.
REQ-033 TX full: wr_en held 10 consecutive cycles with 0x10..0x19 -> tx_full=1 from 9th write edge; exactly 0x10..0x18 transmitted back-to-back, 0x19 absent.
REQ-034 Framing error: frame 0x55 with stop bit 0 -> single-cycle framing_err, rx_empty stays 1; next valid frame 0x66 received correctly.
REQ-035 Reset mid-TX: reset_n low during data bit 3 of 0xFF with 3 bytes queued -> tx=1 immediately, tx_full=0; tx stays 1 after release.
